// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 constants, memory access-type codes and LSU FSM states
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - pipeline-side request/response bundle of the load/store unit
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic              resp_illegal;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal
  );
endinterface

// File: rtl/lsu_align_check.sv
// rtl/lsu_align_check.sv - funct3 decode to memory access types, byte count and error flags
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic       is_store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [2:0] load_type,
  output logic [1:0] store_type,
  output logic [2:0] nbytes,
  output logic       illegal,
  output logic       misaligned
);

  always_comb begin
    load_type  = LT_LB;
    store_type = ST_SB;
    nbytes     = 3'd1;
    illegal    = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    store_type = ST_SB;
        F3_H:    begin store_type = ST_SH; nbytes = 3'd2; end
        F3_W:    begin store_type = ST_SW; nbytes = 3'd4; end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    load_type = LT_LB;
        F3_BU:   load_type = LT_LBU;
        F3_H:    begin load_type = LT_LH;  nbytes = 3'd2; end
        F3_HU:   begin load_type = LT_LHU; nbytes = 3'd2; end
        F3_W:    begin load_type = LT_LW;  nbytes = 3'd4; end
        default: illegal = 1'b1;
      endcase
    end
    // Illegal wins, so an illegal request never also reports misalignment.
    misaligned = !illegal && ((nbytes == 3'd2 && addr_lo[0]) ||
                              (nbytes == 3'd4 && addr_lo != 2'b00));
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store initiator between MEM stage and byte-addressed data memory
// Optional LSU_MISALIGN_SPLIT_EN: misaligned accesses run as sequential byte sub-accesses.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n_i,
  lsu_mem_ctrl_if.slave     bus,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic [2:0]        mem_load_type_o,
  output logic [1:0]        mem_store_type_o,
  input  logic [31:0]       mem_rd_data_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic              is_store_q, illegal_q, misal_q, split_q;
  logic [2:0]        load_type_q;
  logic [1:0]        store_type_q, byte_idx_q, last_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, rdata_final;
  logic [3:0]        wait_q;

  logic [2:0] dec_load_type, dec_nbytes;
  logic [1:0] dec_store_type;
  logic       dec_illegal, dec_misal;
  logic       accept, access_last, sub_more;

  lsu_align_check u_align_check (
    .is_store   (bus.req_is_store),
    .funct3     (bus.req_funct3),
    .addr_lo    (bus.req_addr[1:0]),
    .load_type  (dec_load_type),
    .store_type (dec_store_type),
    .nbytes     (dec_nbytes),
    .illegal    (dec_illegal),
    .misaligned (dec_misal)
  );

  assign accept      = (state_q == S_IDLE) && bus.req_valid;
  assign access_last = (state_q == S_ACCESS) && (wait_q == WAIT_LAST);
  assign sub_more    = split_q && (byte_idx_q != last_idx_q);
  // Split loads assemble raw bytes; LH sign extension happens once all bytes are in.
  assign rdata_final = (split_q && load_type_q == LT_LH) ?
                       {{16{rdata_q[15]}}, rdata_q[15:0]} : rdata_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_rdata       = 32'h0;
    bus.resp_misaligned  = 1'b0;
    bus.resp_illegal     = 1'b0;
    mem_rd_en_o          = 1'b0;
    mem_wr_en_o          = 1'b0;
    mem_addr_o           = '0;
    mem_wr_data_o        = 32'h0;
    mem_load_type_o      = 3'b000;
    mem_store_type_o     = 2'b00;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_d = (dec_illegal || (dec_misal && !SPLIT_EN)) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_rd_en_o      = !is_store_q;
        mem_wr_en_o      = is_store_q && (wait_q == WAIT_LAST);
        mem_addr_o       = addr_q + ADDR_W'(byte_idx_q);
        mem_load_type_o  = split_q ? LT_LBU : load_type_q;
        mem_store_type_o = split_q ? ST_SB : store_type_q;
        mem_wr_data_o    = split_q ? {24'h0, wdata_q[{byte_idx_q, 3'b000} +: 8]} : wdata_q;
        if (access_last && !sub_more) state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid      = 1'b1;
        bus.resp_rdata      = rdata_final;
        bus.resp_misaligned = misal_q;
        bus.resp_illegal    = illegal_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      is_store_q   <= 1'b0;
      illegal_q    <= 1'b0;
      misal_q      <= 1'b0;
      split_q      <= 1'b0;
      load_type_q  <= 3'b000;
      store_type_q <= 2'b00;
      byte_idx_q   <= 2'b00;
      last_idx_q   <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      wait_q       <= 4'h0;
    end else if (accept) begin
      is_store_q   <= bus.req_is_store;
      illegal_q    <= dec_illegal;
      misal_q      <= dec_misal && !SPLIT_EN;
      split_q      <= dec_misal && SPLIT_EN;
      load_type_q  <= dec_load_type;
      store_type_q <= dec_store_type;
      byte_idx_q   <= 2'b00;
      last_idx_q   <= (dec_misal && SPLIT_EN) ? 2'(dec_nbytes - 3'd1) : 2'b00;
      addr_q       <= bus.req_addr;
      wdata_q      <= bus.req_wdata;
      rdata_q      <= 32'h0;
      wait_q       <= 4'h0;
    end else if (state_q == S_ACCESS) begin
      if (!access_last) begin
        wait_q <= wait_q + 4'h1;
      end else begin
        wait_q <= 4'h0;
        if (!is_store_q) begin
          if (split_q) rdata_q[{byte_idx_q, 3'b000} +: 8] <= mem_rd_data_i[7:0];
          else         rdata_q <= mem_rd_data_i;
        end
        if (sub_more) byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed scoreboard bench for lsu_mem_ctrl with a byte memory model
module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(8)) ifa ();
  lsu_mem_ctrl_if #(.ADDR_W(8)) ifb ();

  logic        rd_en_a, wr_en_a, rd_en_b, wr_en_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] wd_a, wd_b, rd_a, rd_b;
  logic [2:0]  lt_a, lt_b;
  logic [1:0]  st_a, st_b;

  lsu_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst_n_i(rst_n), .bus(ifa),
    .mem_rd_en_o(rd_en_a), .mem_wr_en_o(wr_en_a), .mem_addr_o(addr_a),
    .mem_wr_data_o(wd_a), .mem_load_type_o(lt_a), .mem_store_type_o(st_a),
    .mem_rd_data_i(rd_a)
  );

  lsu_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst_n_i(rst_n), .bus(ifb),
    .mem_rd_en_o(rd_en_b), .mem_wr_en_o(wr_en_b), .mem_addr_o(addr_b),
    .mem_wr_data_o(wd_b), .mem_load_type_o(lt_b), .mem_store_type_o(st_b),
    .mem_rd_data_i(rd_b)
  );

  logic [7:0] mem [256];
  logic       mem_clr = 1'b0;
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h0;
  logic [7:0] pre_data = 8'h0;

  function automatic logic [31:0] mem_rd(input logic [7:0] b0, b1, b2, b3, input logic [2:0] t);
    case (t)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {24'h0, b0};
      3'b010:  return {{16{b1[7]}}, b1, b0};
      3'b011:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always_comb rd_a = mem_rd(mem[addr_a], mem[8'(addr_a + 8'd1)], mem[8'(addr_a + 8'd2)], mem[8'(addr_a + 8'd3)], lt_a);
  always_comb rd_b = mem_rd(mem[addr_b], mem[8'(addr_b + 8'd1)], mem[8'(addr_b + 8'd2)], mem[8'(addr_b + 8'd3)], lt_b);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (wr_en_a) begin
        mem[addr_a] <= wd_a[7:0];
        if (st_a != 2'b00) mem[8'(addr_a + 8'd1)] <= wd_a[15:8];
        if (st_a == 2'b10) begin
          mem[8'(addr_a + 8'd2)] <= wd_a[23:16];
          mem[8'(addr_a + 8'd3)] <= wd_a[31:24];
        end
      end
      if (wr_en_b) begin
        mem[addr_b] <= wd_b[7:0];
        if (st_b != 2'b00) mem[8'(addr_b + 8'd1)] <= wd_b[15:8];
        if (st_b == 2'b10) begin
          mem[8'(addr_b + 8'd2)] <= wd_b[23:16];
          mem[8'(addr_b + 8'd3)] <= wd_b[31:24];
        end
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  string       tname = "reset";
  exp_t        exp_q[$];
  logic [15:0] wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tname, tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic [31:0] rdata, input logic mis, input logic ill);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s/unexpected_resp observed=%0h expected=none", tname, rdata);
    end else begin
      e = exp_q.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("misaligned", {31'h0, mis}, {31'h0, e.mis});
      chk("illegal", {31'h0, ill}, {31'h0, e.ill});
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_a(input logic st, input logic [2:0] f3, input logic [7:0] ad, input logic [31:0] wd,
                       output int lat, output int rd_cyc, output int wr_cyc,
                       output logic [2:0] lt_seen, output logic [1:0] st_seen);
    int n;
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_is_store = st; ifa.req_funct3 = f3;
    ifa.req_addr = ad; ifa.req_wdata = wd;
    n = 0;
    while (!ifa.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 ifa.req_valid = 1'b0;
    lat = -1; rd_cyc = 0; wr_cyc = 0; lt_seen = 3'h7; st_seen = 2'h3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rd_en_a) begin
        if (rd_cyc == 0) lt_seen = lt_a;
        rd_cyc++;
      end
      if (wr_en_a) begin
        if (wr_cyc == 0) st_seen = st_a;
        wr_cyc++;
        wlog.push_back({addr_a, wd_a[7:0]});
      end
      if (ifa.resp_valid) begin
        lat = k;
        sb_pop(ifa.resp_rdata, ifa.resp_misaligned, ifa.resp_illegal);
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $error("FAIL %s/timeout observed=no_resp expected=resp", tname);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rd, wr, wr_b, rsp_b;
    logic [2:0] lt;
    logic [1:0] st;
    logic [5:0] rdy_v, rsp_v;

    ifa.req_valid = 1'b0; ifa.req_is_store = 1'b0; ifa.req_funct3 = 3'h0;
    ifa.req_addr = 8'h0; ifa.req_wdata = 32'h0;
    ifb.req_valid = 1'b0; ifb.req_is_store = 1'b0; ifb.req_funct3 = 3'h0;
    ifb.req_addr = 8'h0; ifb.req_wdata = 32'h0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    chk("ready", {31'h0, ifa.req_ready}, 32'h1);
    chk("resp_valid", {31'h0, ifa.resp_valid}, 32'h0);
    chk("rd_en", {31'h0, rd_en_a}, 32'h0);
    chk("wr_en", {31'h0, wr_en_a}, 32'h0);
    chk("mem_addr", {24'h0, addr_a}, 32'h0);
    chk("resp_rdata", ifa.resp_rdata, 32'h0);
    rst_n = 1'b1;

    tname = "lw_aligned";
    preload(8'h00, 8'h11);
    exp_q.push_back('{rdata: 32'h00000011, mis: 1'b0, ill: 1'b0});
    run_a(1'b0, 3'b010, 8'h00, 32'h0, lat, rd, wr, lt, st);
    chk("latency", lat, 3);
    chk("rd_cycles", rd, 2);
    chk("wr_cycles", wr, 0);
    chk("load_type", {29'h0, lt}, 32'h4);

    tname = "sb";
    wlog.delete();
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0, ill: 1'b0});
    run_a(1'b1, 3'b000, 8'h05, 32'hDEADBEEF, lat, rd, wr, lt, st);
    chk("wr_pulses", wr, 1);
    chk("store_type", {30'h0, st}, 32'h0);
    chk("wr_byte", {16'h0, wlog[0]}, 32'h05EF);
    chk("mem5", {24'h0, mem[5]}, 32'hEF);

    tname = "lbu";
    exp_q.push_back('{rdata: 32'h000000EF, mis: 1'b0, ill: 1'b0});
    run_a(1'b0, 3'b100, 8'h05, 32'h0, lat, rd, wr, lt, st);
    tname = "lb";
    exp_q.push_back('{rdata: 32'hFFFFFFEF, mis: 1'b0, ill: 1'b0});
    run_a(1'b0, 3'b000, 8'h05, 32'h0, lat, rd, wr, lt, st);

    tname = "sh_lh_lhu";
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0, ill: 1'b0});
    run_a(1'b1, 3'b001, 8'h10, 32'h1234ABCD, lat, rd, wr, lt, st);
    exp_q.push_back('{rdata: 32'hFFFFABCD, mis: 1'b0, ill: 1'b0});
    run_a(1'b0, 3'b001, 8'h10, 32'h0, lat, rd, wr, lt, st);
    exp_q.push_back('{rdata: 32'h0000ABCD, mis: 1'b0, ill: 1'b0});
    run_a(1'b0, 3'b101, 8'h10, 32'h0, lat, rd, wr, lt, st);

    tname = "sw_lw";
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0, ill: 1'b0});
    run_a(1'b1, 3'b010, 8'h20, 32'h80706050, lat, rd, wr, lt, st);
    exp_q.push_back('{rdata: 32'h80706050, mis: 1'b0, ill: 1'b0});
    run_a(1'b0, 3'b010, 8'h20, 32'h0, lat, rd, wr, lt, st);

    tname = "lh_misaligned";
    preload(8'h02, 8'h80);
    exp_q.push_back(SPLIT ? '{rdata: 32'hFFFF8000, mis: 1'b0, ill: 1'b0}
                          : '{rdata: 32'h0, mis: 1'b1, ill: 1'b0});
    run_a(1'b0, 3'b001, 8'h01, 32'h0, lat, rd, wr, lt, st);
    chk("rd_cycles", rd, SPLIT ? 4 : 0);
    chk("wr_cycles", wr, 0);
    chk("latency", lat, SPLIT ? 5 : 1);

    tname = "sw_wrap";
    wlog.delete();
    exp_q.push_back('{rdata: 32'h0, mis: !SPLIT, ill: 1'b0});
    run_a(1'b1, 3'b010, 8'hFE, 32'h44332211, lat, rd, wr, lt, st);
    chk("wr_pulses", wr, SPLIT ? 4 : 0);
    for (int i = 0; i < wlog.size(); i++)
      chk("split_write", {16'h0, wlog[i]}, {16'h0, 8'(8'hFE + 8'(i)), 8'(8'h11 * (i + 1))});

    tname = "lw_misaligned";
    exp_q.push_back(SPLIT ? '{rdata: 32'hEF000080, mis: 1'b0, ill: 1'b0}
                          : '{rdata: 32'h0, mis: 1'b1, ill: 1'b0});
    run_a(1'b0, 3'b010, 8'h02, 32'h0, lat, rd, wr, lt, st);

    tname = "store_illegal";
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0, ill: 1'b1});
    run_a(1'b1, 3'b011, 8'h31, 32'h12345678, lat, rd, wr, lt, st);
    chk("wr_cycles", wr, 0);
    chk("latency", lat, 1);

    tname = "back_to_back";
    exp_q.push_back('{rdata: 32'h80706050, mis: 1'b0, ill: 1'b0});
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0, ill: 1'b1});
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_is_store = 1'b0; ifa.req_funct3 = 3'b010; ifa.req_addr = 8'h20;
    @(posedge clk);
    #1 ifa.req_funct3 = 3'b011; ifa.req_addr = 8'h00;
    rdy_v = '0; rsp_v = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rdy_v[k-1] = ifa.req_ready;
      rsp_v[k-1] = ifa.resp_valid;
      if (ifa.resp_valid) sb_pop(ifa.resp_rdata, ifa.resp_misaligned, ifa.resp_illegal);
      if (k == 4) begin
        @(posedge clk);
        #1 ifa.req_valid = 1'b0;
      end
    end
    chk("ready_pattern", {26'h0, rdy_v}, 32'b101000);
    chk("resp_pattern", {26'h0, rsp_v}, 32'b010100);
    chk("sb_empty", exp_q.size(), 0);

    tname = "reset_mid_store";
    wr_b = 0; rsp_b = 0;
    @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_is_store = 1'b1; ifb.req_funct3 = 3'b010;
    ifb.req_addr = 8'h40; ifb.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 ifb.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (wr_en_b) wr_b++;
      if (ifb.resp_valid) rsp_b++;
    end
    chk("in_access", {31'h0, ifb.req_ready}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'h0, wr_en_b}, 32'h0);
    chk("rst_addr", {24'h0, addr_b}, 32'h0);
    chk("rst_wr_data", wd_b, 32'h0);
    chk("rst_ready", {31'h0, ifb.req_ready}, 32'h1);
    repeat (2) begin
      @(negedge clk);
      if (wr_en_b) wr_b++;
      if (ifb.resp_valid) rsp_b++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (wr_en_b) wr_b++;
      if (ifb.resp_valid) rsp_b++;
    end
    chk("wr_pulses", wr_b, 0);
    chk("responses", rsp_b, 0);
    chk("mem_unchanged", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0);
    chk("ready_after", {31'h0, ifb.req_ready}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
